// File: rtl/cobi_result_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cobi_result_deser: packs the serial result bit stream LSB-first into      |
// | words behind a small FIFO and tracks per-frame bit counts.  Rev 1.0       |
// +--------------------------------------------------------------------------+
module cobi_result_deser #(
  parameter int OUT_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int EXPECTED_BITS = 86,
  parameter int CNT_WIDTH     = 9
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 clr,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic                 s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frame_bits,
  output logic                 len_err
);

  localparam int c_IDXW = $clog2(OUT_WIDTH);
  localparam int c_PTRW = $clog2(FIFO_DEPTH);
  localparam logic [c_IDXW-1:0]    c_IDX_LAST = c_IDXW'(OUT_WIDTH - 1);
  localparam logic [c_PTRW:0]      c_FULL     = (c_PTRW + 1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] c_EXPECTED = CNT_WIDTH'(EXPECTED_BITS);

  logic [OUT_WIDTH-1:0] r_acc;
  logic [c_IDXW-1:0]    r_idx;
  logic [OUT_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [c_PTRW-1:0]    r_wr_ptr;
  logic [c_PTRW-1:0]    r_rd_ptr;
  logic [c_PTRW:0]      r_count;
  logic [CNT_WIDTH-1:0] r_bcnt;
  logic [CNT_WIDTH-1:0] r_frame_bits;
  logic                 r_frame_done;
  logic                 r_len_err;

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [OUT_WIDTH-1:0] w_word;
  logic [CNT_WIDTH-1:0] w_bcnt_next;

  assign s_ready  = (r_count != c_FULL);
  assign m_valid  = (r_count != '0);
  assign w_accept = s_valid && s_ready;
  assign w_push   = w_accept && ((r_idx == c_IDX_LAST) || s_last);
  assign w_pop    = m_valid && m_ready;

  // Bits above r_idx are already zero, so the outgoing word is acc plus the new bit.
  always_comb begin
    w_word        = r_acc;
    w_word[r_idx] = s_data;
  end

  assign w_bcnt_next = (r_bcnt == c_CNT_MAX) ? r_bcnt : r_bcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_word;
      r_mem_last[r_wr_ptr] <= s_last;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_acc        <= '0;
      r_idx        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_bcnt       <= '0;
      r_frame_bits <= '0;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
    end else if (clr) begin
      r_acc        <= '0;
      r_idx        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_bcnt       <= '0;
      r_frame_bits <= '0;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_push) begin
          r_acc <= '0;
          r_idx <= '0;
        end else begin
          r_acc <= w_word;
          r_idx <= r_idx + 1'b1;
        end
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      r_frame_done <= w_accept && s_last;
      if (w_accept) begin
        if (s_last) begin
          r_bcnt       <= '0;
          r_frame_bits <= w_bcnt_next;
          if (w_bcnt_next != c_EXPECTED) r_len_err <= 1'b1;
        end else begin
          r_bcnt <= w_bcnt_next;
        end
      end
    end
  end

  // An empty FIFO presents zeros rather than stale head contents.
  assign m_data     = m_valid ? r_mem_data[r_rd_ptr] : '0;
  assign m_last     = m_valid && r_mem_last[r_rd_ptr];
  assign frame_done = r_frame_done;
  assign frame_bits = r_frame_bits;
  assign len_err    = r_len_err;

endmodule
`default_nettype wire

// File: doc/cobi_result_deser.md
# cobi_result_deser

Downstream stage of `top_cobifive`: consumes the core's 1-bit serial result stream (`m_valid/m_ready/m_last/m_data`) and repacks it into OUT_WIDTH-bit words on a valid/ready stream toward the host interface. Bits are packed LSB-first and buffered in a small word FIFO so the core sees backpressure only when the buffer is full. The block also reports per-frame bit count and a sticky length-error flag against the expected spin-vector length.

## Interface
- OUT_WIDTH, 16: output word width (bits per packed word).
- FIFO_DEPTH, 4: word FIFO entries; power of two, at least 2.
- EXPECTED_BITS, 86: expected bits per frame; used for the length check.
- CNT_WIDTH, 9: width of the frame bit counter.

Ports:
- clk  in  1  clock.
- resetb  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous soft clear; same effect as reset; overrides all other inputs.
- s_valid  in  1  serial bit valid (from core m_valid).
- s_ready  out  1  bit accepted when s_valid&&s_ready.
- s_last  in  1  marks the final bit of a frame.
- s_data  in  1  serial result bit.
- m_valid  out  1  FIFO head word valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  head word holds the frame's final bit.
- m_data  out  OUT_WIDTH  packed word.
- frame_done  out  1  one-cycle pulse after a frame's last bit is accepted.
- frame_bits  out  CNT_WIDTH  bit count of the most recent completed frame.
- len_err  out  1  sticky; set when a completed frame's count is not EXPECTED_BITS.

## Operation
- Accumulator acc[OUT_WIDTH-1:0] plus bit index idx.
  - On accept: acc[idx] <= s_data.
  - Word completes when idx==OUT_WIDTH-1 or s_last. On completion, push {acc with the new bit, s_last} into the FIFO, then clear acc to 0 and idx to 0.
  - Otherwise idx increments.
- Final partial word: bits above the last written bit are 0 (acc is cleared after each push).
- s_ready = (fifo_count != FIFO_DEPTH), combinational from the registered count. A push therefore never overflows.
- Push and pop in the same cycle: allowed in any state. Count is unchanged; the pushed data lands behind the current head.
- FIFO outputs:
  - m_valid = (fifo_count != 0).
  - m_data and m_last come from the head entry.
  - Pop on m_valid&&m_ready.
  - Empty-head m_data/m_last read as 0.
- Bit counter bcnt increments on each accepted bit and saturates at 2^CNT_WIDTH-1.
- On accepting the s_last bit:
  - frame_bits <= bcnt+1 (saturated).
  - frame_done pulses on the next cycle.
  - len_err is set if (bcnt+1) != EXPECTED_BITS.
  - bcnt <= 0.
- len_err is cleared only by resetb or clr.
- Frames are not interleaved. The next frame's first bit may follow s_last on the very next cycle.
- Resetting mid-frame (reset or clr) discards acc, FIFO contents and bcnt. The block produces no partial output.

## Timing
- Reset values:
  - s_ready=1 (FIFO empty), m_valid=0, m_data=0, m_last=0.
  - frame_done=0, frame_bits=0, len_err=0.
  - Internal state: idx=0, acc=0, bcnt=0, fifo_count=0.
- Latency: the bit that completes a word is accepted at edge N; m_valid is high after edge N (visible in cycle N+1).
- frame_done: high for exactly one cycle, starting the cycle after the s_last acceptance edge. frame_bits and len_err update on that same edge.
- FIFO full: s_ready drops in the cycle after the push that fills the FIFO. It rises in the cycle after a pop, because it is derived from the registered count.
- With m_ready held high, throughput is one bit per cycle indefinitely. The FIFO never exceeds 1 entry.
- m_data and m_last are stable while m_valid&&!m_ready.

## Test plan
- 86-bit frame, bit i = i[0]^i[2], m_ready=1 -> 6 words: five of 0x????, then a 6-bit tail word with bits[15:6]=0. m_last set only on word 6. frame_bits=86, len_err=0, one frame_done pulse.
- Same frame with m_ready=0 throughout -> s_ready low after 4 words (64 bits accepted). Release m_ready -> remaining bits flow, word order intact, no loss or duplication.
- 16-bit frame of 0xA5C3 -> single word 0xA5C3 with m_last=1. frame_bits=16, len_err=1.
- 1-bit frame with s_data=1 and s_last=1 -> word 0x0001 with m_last=1. frame_bits=1, len_err=1. Then an 86-bit frame -> len_err stays 1 until clr.
- Two back-to-back 86-bit frames with random m_ready -> 12 words, m_last on words 6 and 12, two frame_done pulses.
- Assert resetb low after 40 bits of a frame -> all outputs return to reset values. The next full frame produces exactly 6 correct words.
